// File: rtl/decode_stage_p.sv
// ID stage: field split, 2R/1W register file, immediate sign-extension, ID/EX register with
// valid/ready, flush and load-use bubble. Optional write-through read: define DECODE_BYPASS_EN.
module decode_stage_rd #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3,
  parameter int NREG   = 8
) (
  input  logic [NREG-1:0][DATA_W-1:0] rf_i,
  input  logic [RA_W-1:0]             addr_i,
  input  logic                        byp_hit_i,
  input  logic [DATA_W-1:0]           byp_data_i,
  output logic [DATA_W-1:0]           data_o
);
  always_comb begin
    data_o = '0;
    if (byp_hit_i)          data_o = byp_data_i;
    else if (addr_i != '0)  data_o = rf_i[addr_i];
  end
endmodule

module decode_stage_p #(
  parameter int                DATA_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                PC_W     = 16,
  parameter int                OPC_W    = 3,
  parameter int                RA_W     = 3,
  parameter int                IMM_W    = 7,
  parameter logic [OPC_W-1:0]  LOAD_OPC = 3'b100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [RA_W-1:0]    out_rs,
  output logic [RA_W-1:0]    out_rt,
  output logic [RA_W-1:0]    out_rd,
  output logic [DATA_W-1:0]  out_rs_data,
  output logic [DATA_W-1:0]  out_rt_data,
  output logic [DATA_W-1:0]  out_imm,
  output logic [PC_W-1:0]    out_pc,
  input  logic               flush,
  input  logic               wb_we,
  input  logic [RA_W-1:0]    wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               hazard
);
  localparam int NREG = 2**RA_W;
  localparam int NRP  = 2;

  generate
    if (RA_W*3 + OPC_W > INSTR_W) begin : g_bad_fields
      $error("decode_stage_p: RA_W*3+OPC_W exceeds INSTR_W");
    end
    if (IMM_W > DATA_W) begin : g_bad_imm
      $error("decode_stage_p: IMM_W exceeds DATA_W");
    end
  endgenerate

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc;
  } idex_t;

  logic [NREG-1:0][DATA_W-1:0] rf_q;
  logic [NRP-1:0][RA_W-1:0]    rd_addr;
  logic [NRP-1:0]              byp_hit;
  logic [NRP-1:0][DATA_W-1:0]  rd_data;
  idex_t                       dec, idex_q, idex_d;
  logic                        vld_q, vld_d;
  logic                        adv;

  // Field split: opcode, rs, rt, rd packed MSB-first; immediate from the low bits.
  assign dec.opc = in_instr[INSTR_W-1 -: OPC_W];
  assign dec.rs  = in_instr[INSTR_W-OPC_W-1 -: RA_W];
  assign dec.rt  = in_instr[INSTR_W-OPC_W-RA_W-1 -: RA_W];
  assign dec.rd  = in_instr[INSTR_W-OPC_W-2*RA_W-1 -: RA_W];
  assign dec.imm = {{(DATA_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
  assign dec.pc  = in_pc;
  assign dec.rs_data = rd_data[0];
  assign dec.rt_data = rd_data[1];

  assign rd_addr = {dec.rt, dec.rs};

  genvar p;
  generate
    for (p = 0; p < NRP; p++) begin : g_rp
`ifdef DECODE_BYPASS_EN
      assign byp_hit[p] = wb_we && (wb_addr == rd_addr[p]) && (rd_addr[p] != '0);
`else
      assign byp_hit[p] = 1'b0;
`endif
      decode_stage_rd #(.DATA_W(DATA_W), .RA_W(RA_W), .NREG(NREG)) u_rd (
        .rf_i       (rf_q),
        .addr_i     (rd_addr[p]),
        .byp_hit_i  (byp_hit[p]),
        .byp_data_i (wb_data),
        .data_o     (rd_data[p])
      );
    end
  endgenerate

  // R0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q <= '0;
    end else if (wb_we && wb_addr != '0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign hazard = in_valid && vld_q && (idex_q.opc == LOAD_OPC) && (idex_q.rt != '0) &&
                  ((idex_q.rt == dec.rs) || (idex_q.rt == dec.rt));
  assign adv      = ~vld_q | out_ready;
  assign in_ready = adv & ~hazard & ~flush;

  always_comb begin
    vld_d  = vld_q;
    idex_d = idex_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (adv) begin
      if (hazard) begin
        vld_d = 1'b0;
      end else begin
        vld_d = in_valid;
        if (in_valid) idex_d = dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      idex_q <= '0;
    end else begin
      vld_q  <= vld_d;
      idex_q <= idex_d;
    end
  end

  assign out_valid   = vld_q;
  assign out_opcode  = idex_q.opc;
  assign out_rs      = idex_q.rs;
  assign out_rt      = idex_q.rt;
  assign out_rd      = idex_q.rd;
  assign out_rs_data = idex_q.rs_data;
  assign out_rt_data = idex_q.rt_data;
  assign out_imm     = idex_q.imm;
  assign out_pc      = idex_q.pc;
endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p: reset, decode, stall, load-use, flush, write-through.
module tb_decode_stage_p;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_instr, in_pc;
  logic        out_valid, out_ready;
  logic [2:0]  out_opcode, out_rs, out_rt, out_rd;
  logic [15:0] out_rs_data, out_rt_data, out_imm, out_pc;
  logic        flush, wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        hazard;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage_p dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm), .out_pc(out_pc),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] opc, input logic [2:0] rs,
                                     input logic [2:0] rt, input logic [6:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  task automatic issue(input logic [15:0] instr, input logic [15:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #3;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", {16'd0, out_pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Decode with register reads
    wb_we = 1'b1; wb_addr = 3'd2; wb_data = 16'h1234; cyc();
    wb_addr = 3'd3; wb_data = 16'h00FF; cyc();
    wb_we = 1'b0;
    issue(mk(3'd1, 3'd2, 3'd3, 7'b1111010), 16'h0040); cyc();
    in_valid = 1'b0;
    chk("dec_valid", {31'd0, out_valid}, 32'd1);
    chk("dec_opc", {29'd0, out_opcode}, 32'd1);
    chk("dec_rs", {29'd0, out_rs}, 32'd2);
    chk("dec_rt", {29'd0, out_rt}, 32'd3);
    chk("dec_rd", {29'd0, out_rd}, 32'd7);
    chk("dec_rs_data", {16'd0, out_rs_data}, 32'h1234);
    chk("dec_rt_data", {16'd0, out_rt_data}, 32'h00FF);
    chk("dec_imm", {16'd0, out_imm}, 32'hFFFA);
    chk("dec_pc", {16'd0, out_pc}, 32'h0040);

    // Stall from execute
    issue(mk(3'd0, 3'd1, 3'd1, 7'd5), 16'h0050); cyc();
    out_ready = 1'b0;
    issue(mk(3'd0, 3'd2, 3'd2, 7'd6), 16'h0054);
    #1 chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", {16'd0, out_pc}, 32'h0050);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1; cyc();
    in_valid = 1'b0;
    chk("stall_next_pc", {16'd0, out_pc}, 32'h0054);
    chk("stall_next_imm", {16'd0, out_imm}, 32'h0006);
    cyc();
    chk("stall_no_dup", {31'd0, out_valid}, 32'd0);

    // Load-use bubble
    issue(mk(3'b100, 3'd1, 3'd5, 7'd0), 16'h0100); cyc();
    issue(mk(3'd2, 3'd5, 3'd6, 7'd0), 16'h0104);
    #1;
    chk("lu_hazard", {31'd0, hazard}, 32'd1);
    chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    chk("lu_hazard_clr", {31'd0, hazard}, 32'd0);
    cyc();
    chk("lu_issue_valid", {31'd0, out_valid}, 32'd1);
    chk("lu_issue_pc", {16'd0, out_pc}, 32'h0104);
    issue(mk(3'b100, 3'd1, 3'd0, 7'd0), 16'h0108); cyc();
    issue(mk(3'd2, 3'd0, 3'd6, 7'd0), 16'h010C);
    #1 chk("lu_rt0_hazard", {31'd0, hazard}, 32'd0);
    cyc();
    chk("lu_rt0_pc", {16'd0, out_pc}, 32'h010C);
    chk("lu_rt0_valid", {31'd0, out_valid}, 32'd1);

    // Flush
    issue(mk(3'd3, 3'd1, 3'd2, 7'd9), 16'h0200); flush = 1'b1;
    #1 chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_pc_hold", {16'd0, out_pc}, 32'h010C);
    cyc();
    chk("fl_never", {31'd0, out_valid}, 32'd0);

    // Same-cycle write and read
    wb_we = 1'b1; wb_addr = 3'd4; wb_data = 16'h1111; cyc();
    wb_data = 16'hBEEF;
    issue(mk(3'd0, 3'd4, 3'd0, 7'd0), 16'h0300); cyc();
`ifdef DECODE_BYPASS_EN
    chk("byp_rs_data", {16'd0, out_rs_data}, 32'hBEEF);
`else
    chk("byp_rs_data", {16'd0, out_rs_data}, 32'h1111);
`endif
    wb_addr = 3'd0; wb_data = 16'hDEAD;
    issue(mk(3'd0, 3'd0, 3'd4, 7'd0), 16'h0304); cyc();
    wb_we = 1'b0;
    chk("r0_same_cycle", {16'd0, out_rs_data}, 32'h0000);
    chk("r4_after_wb", {16'd0, out_rt_data}, 32'hBEEF);
    issue(mk(3'd0, 3'd0, 3'd0, 7'd0), 16'h0308); cyc();
    chk("r0_after_wb", {16'd0, out_rs_data}, 32'h0000);
    chk("mid_valid_pre", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_pc", {16'd0, out_pc}, 32'd0);
    chk("arst_opc", {29'd0, out_opcode}, 32'd0);
    chk("arst_imm", {16'd0, out_imm}, 32'd0);
    chk("arst_rs_data", {16'd0, out_rs_data}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 1; r < 8; r++) begin
      issue(mk(3'd0, r[2:0], r[2:0], 7'd0), 16'(r));
      cyc();
      chk($sformatf("arst_R%0d", r), {16'd0, out_rs_data}, 32'd0);
    end
    in_valid = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
